node_iface: RTL

- Endpoint network interface that attaches one processing node to the local port of a NoC switch.
- TX path: accepts flits from the core, buffers them, and drives them into the switch's local input port.
- RX path: takes flits from the switch's local output port, checks the destination, buffers them, and presents them to the core.
- Uses the same per-port ready/ready handshake and {valid, addr, data} flit format as the switch.

---
 rtl/noc_pkg.sv | 40 ++++
 rtl/node_iface_if.sv | 44 ++++
 rtl/node_tx_fifo.sv | 45 ++++
 rtl/node_iface.sv | 125 ++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC definitions for the node interface.
//   - default flit geometry and counter widths
//   - flit field offset helpers (valid bit, address LSB, data LSB)
//   - flit_pack: builds {valid=1, addr, data} for any geometry up to FLIT_MAX bits
package noc_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int BUS_SIZE_DEF  = DATA_SIZE_DEF + ADDR_SIZE_DEF + 1;
  localparam int CNT_SIZE_DEF  = 16;
  localparam int ERR_CNT_SIZE  = 8;

  // Widest flit the pack helper can build.
  localparam int FLIT_MAX = 64;

  // Payload always starts at bit 0; the rest depends on geometry.
  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int data_size);
    return data_size;
  endfunction

  function automatic int valid_bit(input int data_size, input int addr_size);
    return data_size + addr_size;
  endfunction

  // Caller zero-extends addr/data to FLIT_MAX and truncates the result
  // to its own bus width.
  function automatic logic [FLIT_MAX-1:0] flit_pack(input logic [FLIT_MAX-1:0] addr,
                                                     input logic [FLIT_MAX-1:0] data,
                                                     input int data_size,
                                                     input int addr_size);
    logic [FLIT_MAX-1:0] f;
    f = (FLIT_MAX'(1) << valid_bit(data_size, addr_size))
      | (addr << addr_lsb(data_size))
      | (data << DATA_LSB);
    return f;
  endfunction

endpackage

// File: rtl/node_iface_if.sv
// node_iface_if: core-side and switch-side handshake bundle of a node interface.
//   core TX : tx_valid/tx_ready, tx_dest, tx_data
//   core RX : rx_valid/rx_ready, rx_data
//   switch  : sw_wr_ready_out/sw_r_ready_in/sw_data_o  (node -> switch)
//             sw_wr_ready_in/sw_r_ready_out/sw_data_i  (switch -> node)
// slave  = the node interface itself, master = the core + switch around it.
interface node_iface_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [ADDR_SIZE-1:0] tx_dest;
  logic [DATA_SIZE-1:0] tx_data;

  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_SIZE-1:0] rx_data;

  logic                 sw_wr_ready_out;
  logic                 sw_r_ready_in;
  logic [BUS_SIZE-1:0]  sw_data_o;

  logic                 sw_wr_ready_in;
  logic                 sw_r_ready_out;
  logic [BUS_SIZE-1:0]  sw_data_i;

  modport slave (
    input  tx_valid, tx_dest, tx_data, rx_ready,
           sw_r_ready_in, sw_wr_ready_in, sw_data_i,
    output tx_ready, rx_valid, rx_data,
           sw_wr_ready_out, sw_data_o, sw_r_ready_out
  );

  modport master (
    output tx_valid, tx_dest, tx_data, rx_ready,
           sw_r_ready_in, sw_wr_ready_in, sw_data_i,
    input  tx_ready, rx_valid, rx_data,
           sw_wr_ready_out, sw_data_o, sw_r_ready_out
  );

endinterface

// File: rtl/node_tx_fifo.sv
// node_tx_fifo: circular FIFO, depth 2**LOG2, with full/empty flags.
//   clk, rst_n     : clock, async active-low reset (clears pointers and storage)
//   push, din      : write when push && !full
//   pop            : read-advance when pop && !empty
//   dout           : head entry straight from storage, 0 when empty
//   full, empty    : occupancy flags
// Pointers carry one extra MSB so full and empty differ on wrap.
module node_tx_fifo #(
  parameter int WIDTH = 37,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2:0]    wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                 (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[LOG2-1:0]] <= din;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/node_iface.sv
// node_iface: endpoint attaching one processing node to a NoC switch local port.
//   clk, a_rst : clock, async active-low reset
//   bus        : node_iface_if.slave (core TX/RX and switch in/out handshakes)
//   tx_cnt     : flits delivered to the switch (wrapping)
//   rx_cnt     : flits delivered to the core (wrapping)
//   err_cnt    : dropped flits, saturating at 255 (bad TX dest, RX addr miss)
//   tx_err     : one-cycle pulse after a core flit rejected for bad dest
// TX: core -> FIFO -> switch. RX: switch -> dest filter -> 2-entry buffer -> core.
module node_iface
  import noc_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NODES_NUM = 9,
  parameter int ADDR      = 0,
  parameter int TX_LOG2   = 2,
  parameter int CNT_SIZE  = CNT_SIZE_DEF,
  parameter int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1
) (
  input  logic                    clk,
  input  logic                    a_rst,
  node_iface_if.slave             bus,
  output logic [CNT_SIZE-1:0]     tx_cnt,
  output logic [CNT_SIZE-1:0]     rx_cnt,
  output logic [ERR_CNT_SIZE-1:0] err_cnt,
  output logic                    tx_err
);
  localparam int                   VBIT     = valid_bit(DATA_SIZE, ADDR_SIZE);
  localparam int                   ALSB     = addr_lsb(DATA_SIZE);
  localparam logic [ADDR_SIZE:0]   DEST_LIM = (ADDR_SIZE+1)'(NODES_NUM);
  localparam logic [ADDR_SIZE-1:0] MY_ADDR  = ADDR_SIZE'(ADDR);

  // Low during reset, high from the first edge after release; keeps both
  // ready outputs at 0 while reset is held.
  logic up;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) up <= 1'b0;
    else        up <= 1'b1;
  end

  // ---------------- TX path ----------------
  logic                tx_hs, tx_bad, tx_push, tx_pop;
  logic                fifo_full, fifo_empty;
  logic [BUS_SIZE-1:0] tx_flit;

  assign bus.tx_ready = up && !fifo_full;
  assign tx_hs        = bus.tx_valid && bus.tx_ready;
  assign tx_bad       = ({1'b0, bus.tx_dest} >= DEST_LIM);
  assign tx_push      = tx_hs && !tx_bad;
  assign tx_flit      = BUS_SIZE'(flit_pack(FLIT_MAX'(bus.tx_dest), FLIT_MAX'(bus.tx_data),
                                            DATA_SIZE, ADDR_SIZE));

  assign bus.sw_wr_ready_out = !fifo_empty;
  assign tx_pop              = bus.sw_wr_ready_out && bus.sw_r_ready_in;

  node_tx_fifo #(
    .WIDTH (BUS_SIZE),
    .LOG2  (TX_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (a_rst),
    .push  (tx_push),
    .din   (tx_flit),
    .pop   (tx_pop),
    .dout  (bus.sw_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- RX path ----------------
  logic [DATA_SIZE-1:0] rx_mem [2];
  logic                 rx_rd;
  logic [1:0]           rx_occ;
  logic                 sw_hs, in_vld, addr_hit, rx_store, rx_miss, rx_pop;

  // Ready to the switch depends only on registered occupancy, so rx_ready
  // never reaches the switch combinationally.
  assign bus.sw_r_ready_out = up && (rx_occ != 2'd2);
  assign sw_hs              = bus.sw_wr_ready_in && bus.sw_r_ready_out;
  assign in_vld             = bus.sw_data_i[VBIT];
  assign addr_hit           = (bus.sw_data_i[VBIT-1:ALSB] == MY_ADDR);
  assign rx_store           = sw_hs && in_vld && addr_hit;
  assign rx_miss            = sw_hs && in_vld && !addr_hit;

  assign bus.rx_valid = (rx_occ != 2'd0);
  assign bus.rx_data  = bus.rx_valid ? rx_mem[rx_rd] : '0;
  assign rx_pop       = bus.rx_valid && bus.rx_ready;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rx_mem[0] <= '0;
      rx_mem[1] <= '0;
      rx_rd     <= 1'b0;
      rx_occ    <= 2'd0;
    end else begin
      // Write slot is the one after the oldest when one entry is held.
      if (rx_store) rx_mem[rx_rd ^ rx_occ[0]] <= bus.sw_data_i[DATA_SIZE-1:DATA_LSB];
      if (rx_pop)   rx_rd <= ~rx_rd;
      rx_occ <= rx_occ + {1'b0, rx_store} - {1'b0, rx_pop};
    end
  end

  // ---------------- statistics ----------------
  logic [1:0]              err_inc;
  logic [ERR_CNT_SIZE:0]   err_sum;

  assign err_inc = {1'b0, tx_hs && tx_bad} + {1'b0, rx_miss};
  assign err_sum = {1'b0, err_cnt} + {{(ERR_CNT_SIZE-1){1'b0}}, err_inc};

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      err_cnt <= '0;
      tx_err  <= 1'b0;
    end else begin
      tx_cnt  <= tx_cnt + CNT_SIZE'(tx_pop);
      rx_cnt  <= rx_cnt + CNT_SIZE'(rx_pop);
      err_cnt <= err_sum[ERR_CNT_SIZE] ? '1 : err_sum[ERR_CNT_SIZE-1:0];
      tx_err  <= tx_hs && tx_bad;
    end
  end

endmodule
